not_not_round_ctrl: RTL and testbench
=====================================

// Module: not_not_round_ctrl
// PURPOSE
//   Round controller sitting directly downstream of the four 3-bit LFSR selectors
//   (not / logic / colour-1 / colour-2). Steps the LFSRs once per round, latches
//   the challenge, waits for one player direction press with a timeout, and judges
//   it. Tracks score and lives; latched challenge fields feed the HEX/LED display.
// PARAMETERS
//   TIMEOUT_CYCLES  50_000_000  answer window per round (1 s at CLOCK_50)
//   RESULT_CYCLES   25_000_000  hold time of result before next round
//   SCORE_W         8           score counter width
//   START_LIVES     3           lives at game start (1..3)
// PORTS
//   clock         in   1        system clock (CLOCK_50)
//   reset         in   1        asynchronous, active-high reset
//   start         in   1        1-cycle pulse; starts game from IDLE or OVER
//   not_sel       in   3        LFSR selector: [1:0] = number of NOTs (0..3)
//   logic_sel     in   3        LFSR selector: [1:0]==2'b11 -> OR round
//   color_sel_1   in   3        LFSR selector: [1:0] = colour/direction A
//   color_sel_2   in   3        LFSR selector: [1:0] = colour/direction B
//   player_valid  in   1        1-cycle pulse: player pressed a direction
//   player_dir    in   2        direction code, valid with player_valid
//   lfsr_step     out  1        1-cycle pulse; drives LFSR enable
//   ch_color_1    out  2        latched colour A
//   ch_color_2    out  2        latched colour B (meaningful when ch_or=1)
//   ch_nots       out  2        latched NOT count
//   ch_or         out  1        latched OR-round flag
//   round_active  out  1        high in WAIT
//   hit / miss    out  1        1-cycle pulses on entering RESULT
//   result_hit    out  1        held through RESULT: 1 = correct
//   score         out  SCORE_W  correct-answer count, saturating
//   lives         out  2        remaining lives
//   game_over     out  1        high in OVER
// BEHAVIOUR
//   Reset (async): state IDLE; all outputs 0 except lives=START_LIVES; timers 0.
//   States: IDLE, STEP, LATCH, WAIT, RESULT, OVER.
//   IDLE  --start--> STEP; start also clears score, sets lives=START_LIVES.
//   STEP  : lfsr_step=1 for exactly this cycle -> LATCH.
//   LATCH : capture ch_* from selectors (already advanced); clear timer -> WAIT.
//   WAIT  : timer++ each cycle. player_valid -> judge, RESULT. timer reaching
//           TIMEOUT_CYCLES-1 with no press -> miss, RESULT. Press in that same
//           cycle wins (judged normally).
//   Judge : accept set S = {ch_color_1} or, if ch_or, {ch_color_1, ch_color_2}.
//           ch_nots even: correct iff player_dir in S; odd: correct iff not in S.
//           Timeout is always a miss.
//   RESULT: hit or miss pulse on first cycle; on hit score+1 (holds at all-ones);
//           on miss lives-1 (same cycle as pulse). Held RESULT_CYCLES cycles, then
//           -> OVER if lives==0 else STEP.
//   OVER  : game_over=1; score/lives hold; start -> STEP with score/lives reinit.
//   player_valid outside WAIT and start outside IDLE/OVER are ignored.
//   ch_* hold their value from LATCH until the next LATCH.
//   Reset asserted mid-round aborts immediately to reset values; no pulses emitted.
//   Latency: start -> lfsr_step 1 cycle; press -> hit/miss 1 cycle.
// TESTING
//   start pulse from IDLE -> lfsr_step high exactly 1 cycle next; round_active 2 cycles later.
//   nots=0, colour A=2, no OR, press dir 2 -> hit pulse, score 0->1, lives stay 3.
//   nots=1, OR, A=1, B=3, press dir 3 -> miss, lives 3->2; press dir 0 instead -> hit.
//   No press, TIMEOUT_CYCLES=16 -> miss 16 cycles after WAIT entry; press on cycle 15 -> judged.
//   Three misses -> game_over=1 after third RESULT; start -> score=0, lives=3, lfsr_step pulse.
//   SCORE_W=2, four hits -> score saturates at 3; reset in WAIT -> IDLE, no hit/miss pulse.

Source files
------------

// File: rtl/not_not_round_ctrl.sv
// Round controller for the NOT-NOT game: steps the selector LFSRs, latches the
// challenge, times the player's answer, judges it and keeps score and lives.
module not_not_round_ctrl #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RESULT_CYCLES  = 25_000_000,
  parameter int SCORE_W        = 8,
  parameter int START_LIVES    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         not_sel,
  input  logic [2:0]         logic_sel,
  input  logic [2:0]         color_sel_1,
  input  logic [2:0]         color_sel_2,
  input  logic               player_valid,
  input  logic [1:0]         player_dir,
  output logic               lfsr_step,
  output logic [1:0]         ch_color_1,
  output logic [1:0]         ch_color_2,
  output logic [1:0]         ch_nots,
  output logic               ch_or,
  output logic               round_active,
  output logic               hit,
  output logic               miss,
  output logic               result_hit,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int MAX_CYCLES = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RESULT_LAST  = TW'(RESULT_CYCLES - 1);
  localparam logic [1:0]    LIVES_INIT   = 2'(START_LIVES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    LATCH  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic          correct_s;
  logic          answer_end_s;
  logic          unused_sel_bits;

  // An odd NOT count inverts the sense of the accept set.
  function automatic logic judge(input logic [1:0] dir, input logic [1:0] c1,
                                 input logic [1:0] c2, input logic or_f,
                                 input logic [1:0] nots);
    logic in_set;
    in_set = (dir == c1) || (or_f && (dir == c2));
    return in_set ^ nots[0];
  endfunction

  assign correct_s       = player_valid && judge(player_dir, ch_color_1, ch_color_2, ch_or, ch_nots);
  assign answer_end_s    = player_valid || (timer_r == TIMEOUT_LAST);
  assign unused_sel_bits = ^{not_sel[2], logic_sel[2], color_sel_1[2], color_sel_2[2]};

  // Round sequencing, judging and score/lives bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      timer_r      <= '0;
      lfsr_step    <= 1'b0;
      ch_color_1   <= 2'd0;
      ch_color_2   <= 2'd0;
      ch_nots      <= 2'd0;
      ch_or        <= 1'b0;
      round_active <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      result_hit   <= 1'b0;
      score        <= '0;
      lives        <= LIVES_INIT;
      game_over    <= 1'b0;
    end else begin
      lfsr_step <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= STEP;
            lfsr_step <= 1'b1;
            score     <= '0;
            lives     <= LIVES_INIT;
          end else begin
            state_r <= IDLE;
          end
        end
        STEP: begin
          state_r <= LATCH;
        end
        LATCH: begin
          ch_color_1   <= color_sel_1[1:0];
          ch_color_2   <= color_sel_2[1:0];
          ch_nots      <= not_sel[1:0];
          ch_or        <= (logic_sel[1:0] == 2'b11);
          timer_r      <= '0;
          round_active <= 1'b1;
          state_r      <= WAIT;
        end
        WAIT: begin
          // A press in the final timeout cycle is still judged on its merits.
          if (answer_end_s) begin
            state_r      <= RESULT;
            round_active <= 1'b0;
            timer_r      <= '0;
            if (correct_s) begin
              hit        <= 1'b1;
              result_hit <= 1'b1;
              if (score != {SCORE_W{1'b1}}) begin
                score <= score + SCORE_W'(1);
              end else begin
                score <= score;
              end
            end else begin
              miss       <= 1'b1;
              result_hit <= 1'b0;
              if (lives != 2'd0) begin
                lives <= lives - 2'd1;
              end else begin
                lives <= lives;
              end
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RESULT: begin
          if (timer_r == RESULT_LAST) begin
            timer_r    <= '0;
            result_hit <= 1'b0;
            if (lives == 2'd0) begin
              state_r   <= OVER;
              game_over <= 1'b1;
            end else begin
              state_r   <= STEP;
              lfsr_step <= 1'b1;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        OVER: begin
          if (start) begin
            state_r   <= STEP;
            lfsr_step <= 1'b1;
            game_over <= 1'b0;
            score     <= '0;
            lives     <= LIVES_INIT;
          end else begin
            state_r <= OVER;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_not_not_round_ctrl.sv
// Directed bench for not_not_round_ctrl with a short answer window (16) and
// a 2-bit score so saturation is reachable quickly.
module tb_not_not_round_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] not_sel, logic_sel, color_sel_1, color_sel_2;
  logic       player_valid;
  logic [1:0] player_dir;
  logic       lfsr_step;
  logic [1:0] ch_color_1, ch_color_2, ch_nots;
  logic       ch_or, round_active, hit, miss, result_hit;
  logic [1:0] score;
  logic [1:0] lives;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  not_not_round_ctrl #(
    .TIMEOUT_CYCLES(16),
    .RESULT_CYCLES (4),
    .SCORE_W       (2),
    .START_LIVES   (3)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .not_sel(not_sel), .logic_sel(logic_sel),
    .color_sel_1(color_sel_1), .color_sel_2(color_sel_2),
    .player_valid(player_valid), .player_dir(player_dir),
    .lfsr_step(lfsr_step), .ch_color_1(ch_color_1), .ch_color_2(ch_color_2),
    .ch_nots(ch_nots), .ch_or(ch_or), .round_active(round_active),
    .hit(hit), .miss(miss), .result_hit(result_hit),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic set_sel(input logic [2:0] n, input logic [2:0] l,
                         input logic [2:0] a, input logic [2:0] b);
    not_sel = n; logic_sel = l; color_sel_1 = a; color_sel_2 = b;
  endtask

  // Returns at the negedge where the judged result is visible.
  task automatic press(input logic [1:0] d);
    player_valid = 1'b1;
    player_dir   = d;
    @(negedge clock);
    player_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the first negedge with round_active high.
  task automatic wait_round();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (round_active) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_round: round_active=%0b required=1 within 40 cycles", round_active);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({lfsr_step, round_active, hit, miss, result_hit, game_over, score, lives,
         ch_color_1, ch_color_2, ch_nots, ch_or} !== {6'b0, 2'd0, 2'd3, 6'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: step=%0b act=%0b hit=%0b miss=%0b score=%0d lives=%0d ch=%0d/%0d/%0d/%0b required lives=3 rest 0",
               lfsr_step, round_active, hit, miss, score, lives, ch_color_1, ch_color_2, ch_nots, ch_or);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({lfsr_step, round_active, lives} !== {1'b0, 1'b0, 2'd3}) begin
      bad++;
      $display("FAIL idle_hold: step=%0b act=%0b lives=%0d required 0 0 3", lfsr_step, round_active, lives);
    end
  endtask

  task automatic test_start();
    set_sel(3'b100, 3'b010, 3'b110, 3'b001);
    pulse_start();
    total++;
    if (lfsr_step !== 1'b1) begin
      bad++;
      $display("FAIL start_step: lfsr_step=%0b required=1", lfsr_step);
    end
    @(negedge clock);
    total++;
    if ({lfsr_step, round_active} !== 2'b00) begin
      bad++;
      $display("FAIL step_width: step=%0b act=%0b required 0 0", lfsr_step, round_active);
    end
    @(negedge clock);
    total++;
    if ({round_active, ch_color_1, ch_color_2, ch_nots, ch_or} !== {1'b1, 2'd2, 2'd1, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL latch: act=%0b c1=%0d c2=%0d nots=%0d or=%0b required 1 2 1 0 0",
               round_active, ch_color_1, ch_color_2, ch_nots, ch_or);
    end
  endtask

  task automatic test_hit_basic();
    press(2'd2);
    total++;
    if ({hit, miss, result_hit, score, lives} !== {3'b101, 2'd1, 2'd3}) begin
      bad++;
      $display("FAIL basic_hit: hit=%0b miss=%0b rh=%0b score=%0d lives=%0d required 1 0 1 1 3",
               hit, miss, result_hit, score, lives);
    end
    @(negedge clock);
    total++;
    if ({hit, result_hit, score} !== {2'b01, 2'd1}) begin
      bad++;
      $display("FAIL hit_pulse_width: hit=%0b rh=%0b score=%0d required 0 1 1", hit, result_hit, score);
    end
  endtask

  task automatic test_or_odd();
    set_sel(3'b001, 3'b111, 3'b001, 3'b011);
    wait_round();
    total++;
    if ({ch_nots, ch_or, ch_color_1, ch_color_2} !== {2'd1, 1'b1, 2'd1, 2'd3}) begin
      bad++;
      $display("FAIL or_latch: nots=%0d or=%0b c1=%0d c2=%0d required 1 1 1 3",
               ch_nots, ch_or, ch_color_1, ch_color_2);
    end
    press(2'd3);
    total++;
    if ({hit, miss, result_hit, score, lives} !== {3'b010, 2'd1, 2'd2}) begin
      bad++;
      $display("FAIL or_odd_miss: hit=%0b miss=%0b rh=%0b score=%0d lives=%0d required 0 1 0 1 2",
               hit, miss, result_hit, score, lives);
    end
    wait_round();
    press(2'd0);
    total++;
    if ({hit, miss, score, lives} !== {2'b10, 2'd2, 2'd2}) begin
      bad++;
      $display("FAIL or_odd_hit: hit=%0b miss=%0b score=%0d lives=%0d required 1 0 2 2",
               hit, miss, score, lives);
    end
    press(2'd0);
    total++;
    if ({hit, miss, score} !== {2'b00, 2'd2}) begin
      bad++;
      $display("FAIL press_in_result: hit=%0b miss=%0b score=%0d required 0 0 2", hit, miss, score);
    end
  endtask

  task automatic test_timeout();
    wait_round();
    repeat (15) @(negedge clock);
    total++;
    if ({miss, round_active} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_early: miss=%0b act=%0b required 0 1", miss, round_active);
    end
    @(negedge clock);
    total++;
    if ({miss, hit, round_active, lives} !== {3'b100, 2'd1}) begin
      bad++;
      $display("FAIL timeout_miss: miss=%0b hit=%0b act=%0b lives=%0d required 1 0 0 1",
               miss, hit, round_active, lives);
    end
    wait_round();
    repeat (15) @(negedge clock);
    press(2'd2);
    total++;
    if ({hit, miss, score, lives} !== {2'b10, 2'd3, 2'd1}) begin
      bad++;
      $display("FAIL last_cycle_press: hit=%0b miss=%0b score=%0d lives=%0d required 1 0 3 1",
               hit, miss, score, lives);
    end
  endtask

  task automatic test_saturation();
    wait_round();
    press(2'd2);
    total++;
    if ({hit, score} !== {1'b1, 2'd3}) begin
      bad++;
      $display("FAIL score_saturate: hit=%0b score=%0d required 1 3", hit, score);
    end
  endtask

  task automatic test_game_over();
    wait_round();
    press(2'd1);
    total++;
    if ({miss, lives} !== {1'b1, 2'd0}) begin
      bad++;
      $display("FAIL last_life: miss=%0b lives=%0d required 1 0", miss, lives);
    end
    repeat (3) @(negedge clock);
    total++;
    if (game_over !== 1'b0) begin
      bad++;
      $display("FAIL over_early: game_over=%0b required 0", game_over);
    end
    @(negedge clock);
    total++;
    if ({game_over, round_active, lfsr_step, score, lives} !== {3'b100, 2'd3, 2'd0}) begin
      bad++;
      $display("FAIL over_state: go=%0b act=%0b step=%0b score=%0d lives=%0d required 1 0 0 3 0",
               game_over, round_active, lfsr_step, score, lives);
    end
    press(2'd2);
    total++;
    if ({hit, miss, score, game_over} !== {2'b00, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL press_in_over: hit=%0b miss=%0b score=%0d go=%0b required 0 0 3 1",
               hit, miss, score, game_over);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    total++;
    if ({lfsr_step, game_over, score, lives} !== {2'b10, 2'd0, 2'd3}) begin
      bad++;
      $display("FAIL restart: step=%0b go=%0b score=%0d lives=%0d required 1 0 0 3",
               lfsr_step, game_over, score, lives);
    end
  endtask

  task automatic test_three_misses();
    wait_round();
    press(2'd1);
    wait_round();
    press(2'd3);
    wait_round();
    press(2'd1);
    total++;
    if ({miss, lives} !== {1'b1, 2'd0}) begin
      bad++;
      $display("FAIL third_miss: miss=%0b lives=%0d required 1 0", miss, lives);
    end
    repeat (4) @(negedge clock);
    total++;
    if ({game_over, score} !== {1'b1, 2'd0}) begin
      bad++;
      $display("FAIL three_miss_over: go=%0b score=%0d required 1 0", game_over, score);
    end
  endtask

  task automatic test_reset_mid();
    set_sel(3'b000, 3'b000, 3'b010, 3'b000);
    pulse_start();
    wait_round();
    press(2'd2);
    total++;
    if ({hit, score} !== {1'b1, 2'd1}) begin
      bad++;
      $display("FAIL pre_reset_hit: hit=%0b score=%0d required 1 1", hit, score);
    end
    wait_round();
    pulse_start();
    total++;
    if ({lfsr_step, round_active} !== 2'b01) begin
      bad++;
      $display("FAIL start_in_wait: step=%0b act=%0b required 0 1", lfsr_step, round_active);
    end
    reset        = 1'b1;
    player_valid = 1'b1;
    player_dir   = 2'd2;
    @(negedge clock);
    total++;
    if ({hit, miss, round_active, game_over, score, lives, ch_color_1} !== {4'b0000, 2'd0, 2'd3, 2'd0}) begin
      bad++;
      $display("FAIL reset_mid: hit=%0b miss=%0b act=%0b go=%0b score=%0d lives=%0d c1=%0d required 0 0 0 0 0 3 0",
               hit, miss, round_active, game_over, score, lives, ch_color_1);
    end
    reset        = 1'b0;
    player_valid = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({hit, miss, round_active, lfsr_step} !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset_idle: hit=%0b miss=%0b act=%0b step=%0b required 0 0 0 0",
               hit, miss, round_active, lfsr_step);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    player_valid = 1'b0;
    player_dir   = 2'd0;
    set_sel(3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clock);
    test_reset();
    test_start();
    test_hit_basic();
    test_or_odd();
    test_timeout();
    test_saturation();
    test_game_over();
    test_restart();
    test_three_misses();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
